line_sensor_proc: RTL and testbench
===================================

Name: line_sensor_proc

Overview:
- Downstream consumer of the ADC controller's three 12-bit channel outputs (ch5 = left, ch6 = centre, ch7 = right IR sensors).
- Samples the channels periodically, block-averages them and applies hysteresis thresholds to produce a line bit per sensor.
- Converts the 3-bit pattern into a signed steering error, a lost-line flag and a node (junction) pulse for the motor/PID stage.

Parameters:
- SAMPLE_DIV, 50000: clk_50 cycles between snapshots (1 ms).
- AVG_LOG2, 2: log2 of snapshots per averaging block (4).
- THRESH_HI, 2400: average at or above this sets the line bit.
- THRESH_LO, 1800: average at or below this clears the line bit. THRESH_LO < THRESH_HI.
- LOST_LIMIT, 8: consecutive all-clear blocks before `lost` asserts.

Ports:
- clk_50  in  1  50 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run/hold control.
- d_in_left  in  12  ADC ch5 value.
- d_in_center  in  12  ADC ch6 value.
- d_in_right  in  12  ADC ch7 value.
- line_bits  out  3  {L,C,R}; 1 = on line.
- line_err  out  4  signed steering error, range -3..+3.
- lost  out  1  line lost.
- node_pulse  out  1  one-cycle junction detect.
- err_valid  out  1  one-cycle strobe when outputs update.

Behaviour:
- Interface: one clock, clk_50. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; FSM in S_IDLE; tick counter, sums, block counter, lost counter and last-sign register all 0.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 while enable=1.
  - tick is asserted for one cycle at SAMPLE_DIV-1, then the counter wraps to 0.
  - enable=0 holds the counter at 0.
- FSM states: S_IDLE, S_ACC, S_CLASS, S_OUT.
  - S_IDLE: on tick, go to S_ACC.
  - S_ACC: add each d_in_* (zero-extended to 12+AVG_LOG2 bits) into its sum. If block count = 2^AVG_LOG2-1, go to S_CLASS; otherwise increment block count and return to S_IDLE.
  - S_CLASS: avg = sum >> AVG_LOG2 per channel. Per channel: bit=1 if avg >= THRESH_HI; bit=0 if avg <= THRESH_LO; otherwise hold the previous bit. Compute err/lost/node.
  - S_OUT: register outputs, pulse err_valid, clear sums and block count, go to S_IDLE.
- Latency: err_valid rises 3 cycles after the tick that supplies the last snapshot of a block.
- Error map for {L,C,R}:
  - 010 → 0
  - 110 → -1
  - 100 → -2
  - 011 → +1
  - 001 → +2
  - 111 → 0
  - 101 → hold previous line_err
  - 000 → -3 if the last nonzero error was negative, +3 if positive, 0 if none since reset
- Last-sign register: updated on every nonzero error except the ±3 cases.
- Lost counter:
  - Increments on each 000 block, saturating at LOST_LIMIT.
  - lost=1 while counter = LOST_LIMIT.
  - Any non-000 block clears the counter and lost in the same update.
- node_pulse: high with err_valid only when the current pattern is 111 and the previous block's pattern was not 111.
- enable falling mid-block: FSM goes to S_IDLE next cycle; sums and block count clear; outputs hold their last values; no err_valid is issued.
- Sum width 12+AVG_LOG2 bits, so overflow cannot occur.

Optional Feature:
- Macro: LINE_INVERT_EN.
- Defined: each average is replaced by 4095-avg before thresholding (white line on black field).
- Undefined: raw average is used (black line reads high).

Decomposition:
- Package lfr_sensor_pkg holds:
  - FSM state enum.
  - ADC_W=12, ERR_W=4.
  - Error code constants ERR_HARD_L=-2, ERR_SOFT_L=-1, ERR_CENTER=0, ERR_SOFT_R=+1, ERR_HARD_R=+2, ERR_LOST_MAG=3.
- Sub-module line_hyst_cmp: one channel's accumulator, average and hysteresis bit, with clear/accumulate/evaluate strobes. Instantiated three times.
- Top level: tick counter, FSM, error map, lost/node logic.

Test Plan (SAMPLE_DIV=4, AVG_LOG2=2):
- Hold L/C/R = 500/3000/500 for 4 ticks → err_valid pulse; line_bits=010, line_err=0, lost=0.
- L/C/R = 3000/3000/500 for one block, then 3000/500/500 → line_err -1, then -2.
- Centre at 3000 for one block, then 2000 (between thresholds) → C bit stays 1; then 1500 → C bit clears.
- Pattern 001 (err +2), then all channels 500 for 8 blocks → line_err=+3 each block; lost=1 from the 8th all-clear block; next 010 block → lost=0, line_err=0.
- Pattern 111 for two blocks → node_pulse on the first block only; line_err=0 both blocks.
- Drop enable mid-block, or pulse rst_n low mid-block → no err_valid. After re-enable, the first err_valid comes after a full 4 new ticks. After reset, all outputs read 0.

Source files
------------

// File: rtl/lfr_sensor_pkg.sv
// Shared types and constants for the line sensor processing chain.
// Optional LINE_INVERT_EN selects white-line-on-black thresholding.
package lfr_sensor_pkg;

    localparam int ADC_W = 12;
    localparam int ERR_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_CLASS,
        S_OUT
    } state_t;

    typedef enum logic [1:0] {
        SGN_NONE,
        SGN_NEG,
        SGN_POS
    } sign_t;

    localparam logic signed [ERR_W-1:0] ERR_HARD_L   = ERR_W'(-2);
    localparam logic signed [ERR_W-1:0] ERR_SOFT_L   = ERR_W'(-1);
    localparam logic signed [ERR_W-1:0] ERR_CENTER   = ERR_W'(0);
    localparam logic signed [ERR_W-1:0] ERR_SOFT_R   = ERR_W'(1);
    localparam logic signed [ERR_W-1:0] ERR_HARD_R   = ERR_W'(2);
    localparam logic signed [ERR_W-1:0] ERR_LOST_MAG = ERR_W'(3);

endpackage

// File: rtl/line_hyst_cmp.sv
// One sensor channel: block accumulator, average and hysteresis bit.
// LINE_INVERT_EN defined: the average is inverted before thresholding.
module line_hyst_cmp
    import lfr_sensor_pkg::*;
#(
    parameter int AVG_LOG2  = 2,
    parameter int THRESH_HI = 2400,
    parameter int THRESH_LO = 1800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             acc,
    input  logic             eval,
    input  logic [ADC_W-1:0] d_in,
    output logic             bit_q,
    output logic             bit_nxt
);

    localparam int SUM_W = ADC_W + AVG_LOG2;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] avg;
    logic [SUM_W-1:0] lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (acc) begin
            sum <= sum + SUM_W'(d_in);
        end
    end

    assign avg = sum >> AVG_LOG2;

`ifdef LINE_INVERT_EN
    assign lvl = SUM_W'((1 << ADC_W) - 1) - avg;
`else
    assign lvl = avg;
`endif

    // Between the two thresholds the previous decision is kept.
    always_comb begin
        bit_nxt = bit_q;
        if (lvl >= SUM_W'(THRESH_HI)) begin
            bit_nxt = 1'b1;
        end else if (lvl <= SUM_W'(THRESH_LO)) begin
            bit_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q <= 1'b0;
        end else if (eval) begin
            bit_q <= bit_nxt;
        end
    end

endmodule

// File: rtl/line_sensor_proc.sv
// Line sensor processor: sampling, averaging, steering error, lost/node.
// Build option LINE_INVERT_EN inverts channel levels (white line).
module line_sensor_proc
    import lfr_sensor_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000,
    parameter int AVG_LOG2   = 2,
    parameter int THRESH_HI  = 2400,
    parameter int THRESH_LO  = 1800,
    parameter int LOST_LIMIT = 8
) (
    input  logic                    clk_50,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [ADC_W-1:0]        d_in_left,
    input  logic [ADC_W-1:0]        d_in_center,
    input  logic [ADC_W-1:0]        d_in_right,
    output logic [2:0]              line_bits,
    output logic signed [ERR_W-1:0] line_err,
    output logic                    lost,
    output logic                    node_pulse,
    output logic                    err_valid
);

    localparam int CNT_W  = $clog2(SAMPLE_DIV);
    localparam int BLK_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int LOST_W = $clog2(LOST_LIMIT + 1);

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    state_t           state;
    state_t           state_nxt;
    logic [BLK_W-1:0] blk_cnt;
    logic             blk_last;
    logic             acc;
    logic             eval;
    logic             clr;
    logic [2:0]       pat;
    logic             l_nxt;
    logic             c_nxt;
    logic             r_nxt;

    logic signed [ERR_W-1:0] err_nxt;
    sign_t                   sign_q;
    sign_t                   sign_nxt;
    logic                    sign_upd;
    logic [LOST_W-1:0]       lost_cnt;
    logic [LOST_W-1:0]       lost_cnt_nxt;

    assign tick = enable && (tick_cnt == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (!enable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign blk_last = (blk_cnt == BLK_W'((1 << AVG_LOG2) - 1));

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (tick) state_nxt = S_ACC;
                S_ACC:   state_nxt = blk_last ? S_CLASS : S_IDLE;
                S_CLASS: state_nxt = S_OUT;
                S_OUT:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        acc  = enable && (state == S_ACC);
        eval = enable && (state == S_CLASS);
        clr  = !enable || (state == S_OUT);
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (clr) begin
            blk_cnt <= '0;
        end else if (acc && !blk_last) begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

    line_hyst_cmp #(
        .AVG_LOG2 (AVG_LOG2),
        .THRESH_HI(THRESH_HI),
        .THRESH_LO(THRESH_LO)
    ) u_left (
        .clk    (clk_50),
        .rst_n  (rst_n),
        .clr    (clr),
        .acc    (acc),
        .eval   (eval),
        .d_in   (d_in_left),
        .bit_q  (line_bits[2]),
        .bit_nxt(l_nxt)
    );

    line_hyst_cmp #(
        .AVG_LOG2 (AVG_LOG2),
        .THRESH_HI(THRESH_HI),
        .THRESH_LO(THRESH_LO)
    ) u_center (
        .clk    (clk_50),
        .rst_n  (rst_n),
        .clr    (clr),
        .acc    (acc),
        .eval   (eval),
        .d_in   (d_in_center),
        .bit_q  (line_bits[1]),
        .bit_nxt(c_nxt)
    );

    line_hyst_cmp #(
        .AVG_LOG2 (AVG_LOG2),
        .THRESH_HI(THRESH_HI),
        .THRESH_LO(THRESH_LO)
    ) u_right (
        .clk    (clk_50),
        .rst_n  (rst_n),
        .clr    (clr),
        .acc    (acc),
        .eval   (eval),
        .d_in   (d_in_right),
        .bit_q  (line_bits[0]),
        .bit_nxt(r_nxt)
    );

    assign pat = {l_nxt, c_nxt, r_nxt};

    // All-clear steers hard toward the side the line was last seen on.
    always_comb begin
        err_nxt  = line_err;
        sign_nxt = sign_q;
        sign_upd = 1'b0;
        unique case (pat)
            3'b010: err_nxt = ERR_CENTER;
            3'b111: err_nxt = ERR_CENTER;
            3'b101: err_nxt = line_err;
            3'b110: begin
                err_nxt  = ERR_SOFT_L;
                sign_nxt = SGN_NEG;
                sign_upd = 1'b1;
            end
            3'b100: begin
                err_nxt  = ERR_HARD_L;
                sign_nxt = SGN_NEG;
                sign_upd = 1'b1;
            end
            3'b011: begin
                err_nxt  = ERR_SOFT_R;
                sign_nxt = SGN_POS;
                sign_upd = 1'b1;
            end
            3'b001: begin
                err_nxt  = ERR_HARD_R;
                sign_nxt = SGN_POS;
                sign_upd = 1'b1;
            end
            3'b000: begin
                if (sign_q == SGN_NEG) begin
                    err_nxt = -ERR_LOST_MAG;
                end else if (sign_q == SGN_POS) begin
                    err_nxt = ERR_LOST_MAG;
                end else begin
                    err_nxt = ERR_CENTER;
                end
            end
            default: err_nxt = line_err;
        endcase
    end

    always_comb begin
        lost_cnt_nxt = '0;
        if (pat == 3'b000) begin
            if (lost_cnt == LOST_W'(LOST_LIMIT)) begin
                lost_cnt_nxt = lost_cnt;
            end else begin
                lost_cnt_nxt = lost_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            line_err   <= '0;
            sign_q     <= SGN_NONE;
            lost_cnt   <= '0;
            lost       <= 1'b0;
            node_pulse <= 1'b0;
            err_valid  <= 1'b0;
        end else begin
            err_valid  <= eval;
            node_pulse <= eval && (pat == 3'b111) && (line_bits != 3'b111);
            if (eval) begin
                line_err <= err_nxt;
                lost_cnt <= lost_cnt_nxt;
                lost     <= (lost_cnt_nxt == LOST_W'(LOST_LIMIT));
                if (sign_upd) begin
                    sign_q <= sign_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_sensor_proc.sv
// Scoreboard bench for line_sensor_proc with a behavioural reference model.
// Directed blocks, randomized per-snapshot blocks, enable-drop and reset.
module tb_line_sensor_proc;

    localparam int SDIV  = 4;
    localparam int NAVG  = 4;
    localparam int LAT   = SDIV * NAVG + 2;
    localparam int TH_HI = 2400;
    localparam int TH_LO = 1800;
    localparam int LLIM  = 8;

    logic              clk_50 = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [11:0]       d_in_left;
    logic [11:0]       d_in_center;
    logic [11:0]       d_in_right;
    logic [2:0]        line_bits;
    logic signed [3:0] line_err;
    logic              lost;
    logic              node_pulse;
    logic              err_valid;

    always #10 clk_50 = ~clk_50;

    line_sensor_proc #(
        .SAMPLE_DIV(SDIV),
        .AVG_LOG2  (2),
        .THRESH_HI (TH_HI),
        .THRESH_LO (TH_LO),
        .LOST_LIMIT(LLIM)
    ) dut (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .enable     (enable),
        .d_in_left  (d_in_left),
        .d_in_center(d_in_center),
        .d_in_right (d_in_right),
        .line_bits  (line_bits),
        .line_err   (line_err),
        .lost       (lost),
        .node_pulse (node_pulse),
        .err_valid  (err_valid)
    );

    typedef struct {
        int bits;
        int err;
        int lost;
        int node;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    int m_bit[3];
    int m_err;
    int m_sign;
    int m_lcnt;
    int m_prev_all;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_bit[i] = 0;
        m_err      = 0;
        m_sign     = 0;
        m_lcnt     = 0;
        m_prev_all = 0;
    endtask

    // Inputs are per-channel block averages.
    task automatic model_block(input int al, input int ac, input int ar);
        int   a[3];
        int   lvl;
        int   n_on;
        exp_t e;
        a[0] = al;
        a[1] = ac;
        a[2] = ar;
        for (int i = 0; i < 3; i++) begin
            lvl = a[i];
`ifdef LINE_INVERT_EN
            lvl = 4095 - lvl;
`endif
            if (lvl >= TH_HI) m_bit[i] = 1;
            else if (lvl <= TH_LO) m_bit[i] = 0;
        end
        n_on = m_bit[0] + m_bit[1] + m_bit[2];
        if (n_on == 0) begin
            m_err = 3 * m_sign;
        end else if (m_bit[0] == 1 && m_bit[2] == 1 && m_bit[1] == 0) begin
            m_err = m_err;
        end else begin
            m_err = (m_bit[2] - m_bit[0]) * ((m_bit[1] == 1) ? 1 : 2);
            if (m_err != 0) m_sign = (m_err > 0) ? 1 : -1;
        end
        if (n_on == 0) m_lcnt = (m_lcnt < LLIM) ? m_lcnt + 1 : LLIM;
        else m_lcnt = 0;
        e.bits     = m_bit[0] * 4 + m_bit[1] * 2 + m_bit[2];
        e.err      = m_err;
        e.lost     = (m_lcnt == LLIM) ? 1 : 0;
        e.node     = (n_on == 3 && m_prev_all == 0) ? 1 : 0;
        m_prev_all = (n_on == 3) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    always @(negedge clk_50) begin
        if (rst_n === 1'b1 && err_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_err_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("line_bits", int'(line_bits), mon_e.bits);
                chk("line_err", int'(line_err), mon_e.err);
                chk("lost", int'(lost), mon_e.lost);
                chk("node_pulse", int'(node_pulse), mon_e.node);
            end
        end
    end

    task automatic wait_ev(output int n);
        bit ok;
        n  = 0;
        ok = 0;
        while (n < LAT + 40 && !ok) begin
            @(negedge clk_50);
            n++;
            if (err_valid === 1'b1) ok = 1;
        end
        if (!ok) chk("err_valid_timeout", 0, 1);
    endtask

    task automatic set_in(input int l, input int c, input int r);
        d_in_left   = 12'(l);
        d_in_center = 12'(c);
        d_in_right  = 12'(r);
    endtask

    task automatic blk_const(input int l, input int c, input int r,
                             output int lat);
        set_in(l, c, r);
        model_block(l, c, r);
        wait_ev(lat);
    endtask

    function automatic int pick(input int mode);
        case (mode)
            0:       return $urandom_range(0, 1700);
            1:       return $urandom_range(2500, 4095);
            2:       return $urandom_range(1700, 2500);
            default: return $urandom_range(0, 4095);
        endcase
    endfunction

    task automatic gen_ch(output int s[4]);
        int m;
        m = $urandom_range(0, 3);
        for (int k = 0; k < 4; k++) s[k] = pick(m);
    endtask

    // Entered on an err_valid sample edge: snapshots land every SDIV cycles.
    task automatic blk_rand();
        int sl[4];
        int sc[4];
        int sr[4];
        int lat;
        gen_ch(sl);
        gen_ch(sc);
        gen_ch(sr);
        model_block((sl[0] + sl[1] + sl[2] + sl[3]) / 4,
                    (sc[0] + sc[1] + sc[2] + sc[3]) / 4,
                    (sr[0] + sr[1] + sr[2] + sr[3]) / 4);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (SDIV) @(negedge clk_50);
            set_in(sl[k], sc[k], sr[k]);
        end
        wait_ev(lat);
    endtask

    initial begin
        int lat;
        model_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        set_in(0, 0, 0);
        repeat (3) @(negedge clk_50);
        chk("rst_line_bits", int'(line_bits), 0);
        chk("rst_line_err", int'(line_err), 0);
        chk("rst_lost", int'(lost), 0);
        chk("rst_node", int'(node_pulse), 0);
        chk("rst_err_valid", int'(err_valid), 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        blk_const(500, 3000, 500, lat);
        chk("first_latency", lat, LAT);
        blk_const(3000, 3000, 500, lat);
        blk_const(3000, 500, 500, lat);
        blk_const(500, 3000, 500, lat);
        blk_const(500, 2000, 500, lat);
        blk_const(500, 1500, 500, lat);
        blk_const(500, 500, 3000, lat);
        for (int i = 0; i < 9; i++) blk_const(500, 500, 500, lat);
        blk_const(500, 3000, 500, lat);
        blk_const(3000, 3000, 3000, lat);
        blk_const(3000, 3000, 3000, lat);
        blk_const(3000, 500, 3000, lat);
        blk_const(500, 2400, 500, lat);
        blk_const(500, 1800, 500, lat);

        for (int i = 0; i < 40; i++) blk_rand();

        blk_const(500, 3000, 500, lat);
        set_in(4095, 4095, 4095);
        repeat (6) @(negedge clk_50);
        enable = 1'b0;
        repeat (8) @(negedge clk_50);
        chk("hold_line_bits", int'(line_bits),
            m_bit[0] * 4 + m_bit[1] * 2 + m_bit[2]);
        chk("hold_line_err", int'(line_err), m_err);
        chk("hold_lost", int'(lost), (m_lcnt == LLIM) ? 1 : 0);
        enable = 1'b1;
        blk_const(2000, 3000, 500, lat);
        chk("reenable_latency", lat, LAT);

        set_in(3000, 3000, 3000);
        repeat (6) @(negedge clk_50);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_50);
        chk("mid_rst_line_bits", int'(line_bits), 0);
        chk("mid_rst_line_err", int'(line_err), 0);
        chk("mid_rst_lost", int'(lost), 0);
        chk("mid_rst_err_valid", int'(err_valid), 0);
        model_reset();
        rst_n = 1'b1;
        blk_const(500, 500, 500, lat);
        chk("post_rst_latency", lat, LAT);
        blk_const(3000, 3000, 3000, lat);

        repeat (5) @(negedge clk_50);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
